// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant source, counter width.
package mem_arb_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-macro signals around the port arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requesters and memory macro side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Loadable down-counter with zero flag, timing the memory latency in the WAIT phase.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for a single-port fixed-latency memory (rst is active-low).
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  if ((ADDR_W == 0) || (DATA_W == 0) || (MEM_LATENCY < 1) || (MEM_LATENCY > 15) ||
      (STARVE_MAX < 1)) begin : g_bad_cfg
    $error("mem_port_arbiter: illegal parameter set");
  end

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

  arb_state_t       state, state_nxt;
  gnt_t             gnt, gnt_nxt;
  logic             grant;
  logic             we_q;
  logic             capture;
  logic             force_if;
  logic             lat_zero;
  logic [LAT_W-1:0] lat_cnt;

  mem_arb_lat_cnt #(.W(LAT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_ISSUE),
    .load_val (LAT_LOAD),
    .dec      (state == ST_WAIT),
    .cnt      (lat_cnt),
    .zero     (lat_zero)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;

  assign force_if = bus.if_req && (starve == SW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (grant) begin
      if (gnt_nxt == GNT_IF) begin
        starve <= '0;
      end else if (bus.if_req) begin
        starve <= starve + SW'(1);
      end
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Capture happens in the WAIT cycle where the counter reads 0 (MEM_LATENCY=1 -> first WAIT cycle)
  assign capture = (state == ST_WAIT) && lat_zero;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    grant     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.d_req || bus.if_req) begin
          grant     = 1'b1;
          state_nxt = ST_ISSUE;
          gnt_nxt   = (bus.d_req && !force_if) ? GNT_D : GNT_IF;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (lat_zero) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      gnt           <= GNT_IF;
      we_q          <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      bus.busy   <= (state_nxt != ST_IDLE);
      bus.mem_en <= grant;
      bus.mem_we <= grant && (gnt_nxt == GNT_D) && bus.d_we;
      bus.if_ack <= capture && (gnt == GNT_IF);
      bus.d_ack  <= capture && (gnt == GNT_D);
      if (grant) begin
        we_q         <= (gnt_nxt == GNT_D) && bus.d_we;
        bus.mem_addr <= (gnt_nxt == GNT_D) ? bus.d_addr : bus.if_addr;
        if (gnt_nxt == GNT_D) begin
          bus.mem_wdata <= bus.d_wdata;
        end
      end
      if (capture) begin
        if (gnt == GNT_IF) begin
          bus.if_rdata <= bus.mem_rdata;
        end else if (!we_q) begin
          bus.d_rdata <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with MEM_LATENCY=1 and one with MEM_LATENCY=3, each with a memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_MAX(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (a1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_MAX(4)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (a3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 memory: fixed instruction at 0x10, data valid only in the mem_en+1 cycle
  logic        v1;
  logic [31:0] r1;
  always @(posedge clk) begin
    v1 <= a1.mem_en;
    r1 <= (a1.mem_addr == 32'h10) ? 32'h0050_0093 : 32'h0;
  end
  assign a1.mem_rdata = v1 ? r1 : 32'hBAD0_BAD0;

  // Latency-3 memory: array with a preload port, data valid only in the mem_en+3 cycle
  logic [31:0] m3 [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_dat;
  logic [31:0] p3_0, p3_1, p3_2;
  logic [2:0]  v3;
  always @(posedge clk) begin
    if (pl_en) m3[pl_idx] <= pl_dat;
    else if (a3.mem_en && a3.mem_we) m3[a3.mem_addr[11:2]] <= a3.mem_wdata;
    p3_0 <= m3[a3.mem_addr[11:2]];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
    v3   <= {v3[1:0], a3.mem_en};
  end
  assign a3.mem_rdata = v3[2] ? p3_2 : 32'hBAD0_BAD0;

  task automatic preload(input logic [31:0] addr, input logic [31:0] dat);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = addr[11:2];
    pl_dat = dat;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Negedges until the selected a3 event (0:if_ack 1:d_ack 2:mem_en 3:!busy), -1 on timeout
  task automatic wait3(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((which == 0 && a3.if_ack) || (which == 1 && a3.d_ack) ||
          (which == 2 && a3.mem_en) || (which == 3 && !a3.busy)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({a1.mem_en, a1.mem_we, a1.if_ack, a1.d_ack, a1.busy, a3.mem_en, a3.mem_we, a3.if_ack,
         a3.d_ack, a3.busy} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b/%b expected 0", {a1.mem_en, a1.mem_we, a1.if_ack, a1.d_ack,
               a1.busy}, {a3.mem_en, a3.mem_we, a3.if_ack, a3.d_ack, a3.busy});
    end
    n_cmp++;
    if ({a1.mem_addr, a1.mem_wdata, a1.if_rdata, a1.d_rdata, a3.mem_addr, a3.if_rdata,
         a3.d_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h %h expected all 0", a1.mem_addr, a1.if_rdata,
               a3.mem_addr, a3.d_rdata);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a1.mem_en, a1.if_ack, a1.d_ack, a1.busy, a3.mem_en, a3.if_ack, a3.d_ack,
           a3.busy} !== 8'b0) begin
        n_bad++;
        $display("FAIL idle_quiet: cycle %0d got %b expected 0", i, {a1.mem_en, a1.if_ack,
                 a1.d_ack, a1.busy, a3.mem_en, a3.if_ack, a3.d_ack, a3.busy});
      end
    end
  endtask

  task automatic test_fetch_l1;
    @(negedge clk);
    a1.if_req  = 1'b1;
    a1.if_addr = 32'h10;
    @(negedge clk);
    n_cmp++;
    if ({a1.mem_en, a1.mem_we, a1.busy, a1.mem_addr} !== {3'b101, 32'h10}) begin
      n_bad++;
      $display("FAIL l1_issue: got en/we/busy=%b%b%b addr=%h expected 101 addr=10", a1.mem_en,
               a1.mem_we, a1.busy, a1.mem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({a1.mem_en, a1.if_ack} !== 2'b00) begin
      n_bad++;
      $display("FAIL l1_wait: got en/ack=%b%b expected 00", a1.mem_en, a1.if_ack);
    end
    @(negedge clk);
    n_cmp++;
    if ({a1.if_ack, a1.d_ack, a1.if_rdata} !== {2'b10, 32'h0050_0093}) begin
      n_bad++;
      $display("FAIL l1_ack: got ack=%b%b rdata=%h expected 10 rdata=00500093", a1.if_ack,
               a1.d_ack, a1.if_rdata);
    end
    a1.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a1.if_ack, a1.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL l1_done: got ack/busy=%b%b expected 00", a1.if_ack, a1.busy);
    end
  endtask

  task automatic test_store_load;
    int n;
    @(negedge clk);
    a3.d_req   = 1'b1;
    a3.d_we    = 1'b1;
    a3.d_addr  = 32'h200;
    a3.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({a3.mem_en, a3.mem_we, a3.mem_addr, a3.mem_wdata} !== {2'b11, 32'h200, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL st_issue: got en/we=%b%b addr=%h wdata=%h expected 11 200 deadbeef",
               a3.mem_en, a3.mem_we, a3.mem_addr, a3.mem_wdata);
    end
    wait3(1, n);
    n_cmp++;
    if (n !== 4) begin
      n_bad++;
      $display("FAIL st_ack_time: got %0d cycles after issue expected 4", n);
    end
    n_cmp++;
    if (a3.d_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL st_rdata_hold: got %h expected 0", a3.d_rdata);
    end
    a3.d_we = 1'b0;
    wait3(2, n);
    n_cmp++;
    if ({n, a3.mem_we, a3.mem_addr} !== {32'd2, 1'b0, 32'h200}) begin
      n_bad++;
      $display("FAIL ld_issue: got %0d cycles we=%b addr=%h expected 2 we=0 addr=200", n,
               a3.mem_we, a3.mem_addr);
    end
    wait3(1, n);
    n_cmp++;
    if ({n, a3.d_rdata} !== {32'd4, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL ld_ack: got %0d cycles rdata=%h expected 4 deadbeef", n, a3.d_rdata);
    end
    a3.d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a3.d_ack, a3.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL ld_done: got ack/busy=%b%b expected 00", a3.d_ack, a3.busy);
    end
  endtask

  task automatic test_both;
    int d_at;
    int i_at;
    d_at = -1;
    i_at = -1;
    @(negedge clk);
    a3.if_req  = 1'b1;
    a3.if_addr = 32'h400;
    a3.d_req   = 1'b1;
    a3.d_we    = 1'b0;
    a3.d_addr  = 32'h204;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a3.if_ack && a3.d_ack) begin
        n_bad++;
        $display("FAIL both_one_ack: cycle %0d got two acks expected at most one", i);
      end
      if (a3.d_ack) begin
        d_at     = i;
        a3.d_req = 1'b0;
        n_cmp++;
        if (a3.d_rdata !== 32'hCAFE_F00D) begin
          n_bad++;
          $display("FAIL both_d_rdata: got %h expected cafef00d", a3.d_rdata);
        end
      end
      if (a3.if_ack) begin
        i_at      = i;
        a3.if_req = 1'b0;
        n_cmp++;
        if (a3.if_rdata !== 32'h1234_5678) begin
          n_bad++;
          $display("FAIL both_if_rdata: got %h expected 12345678", a3.if_rdata);
        end
      end
    end
    n_cmp++;
    if ({d_at, i_at} !== {32'd5, 32'd11}) begin
      n_bad++;
      $display("FAIL both_order: got d_ack@%0d if_ack@%0d expected 5 and 11", d_at, i_at);
    end
  endtask

  task automatic test_starve;
    int         n;
    logic [9:0] seq;
    logic [9:0] exp_seq;
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_seq = 10'b10_0001_0000;
`else
    exp_seq = 10'b00_0000_0000;
`endif
    seq = '0;
    @(negedge clk);
    a3.d_req   = 1'b1;
    a3.d_we    = 1'b0;
    a3.d_addr  = 32'h300;
    a3.if_req  = 1'b1;
    a3.if_addr = 32'h400;
    for (int k = 0; k < 10; k++) begin
      wait3(2, n);
      if (n < 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL starve_timeout: grant %0d got no mem_en expected one", k);
        break;
      end
      seq[k] = (a3.mem_addr == 32'h400);
    end
    n_cmp++;
    if (seq !== exp_seq) begin
      n_bad++;
      $display("FAIL starve_pattern: got %b expected %b (bit k = fetch grant)", seq, exp_seq);
    end
    a3.d_req  = 1'b0;
    a3.if_req = 1'b0;
    wait3(3, n);
    n_cmp++;
    if (n < 0) begin
      n_bad++;
      $display("FAIL starve_drain: got busy stuck expected idle");
    end
  endtask

  task automatic test_reset_mid;
    int   n;
    logic quiet;
    @(negedge clk);
    a3.if_req  = 1'b1;
    a3.if_addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({a3.busy, a3.if_ack, a3.if_rdata} !== {2'b00, 32'h0}) begin
      n_bad++;
      $display("FAIL rst_mid_clear: got busy/ack=%b%b rdata=%h expected 00 0", a3.busy,
               a3.if_ack, a3.if_rdata);
    end
    a3.if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a3.if_ack || a3.d_ack || a3.busy || a3.mem_en) quiet = 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_quiet: got activity after release expected none");
    end
    a3.if_req = 1'b1;
    wait3(0, n);
    n_cmp++;
    if ({n, a3.if_rdata} !== {32'd5, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL rst_mid_refetch: got %0d cycles rdata=%h expected 5 12345678", n, a3.if_rdata);
    end
    a3.if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    pl_en = 1'b0;
    pl_idx = '0;
    pl_dat = '0;
    a1.if_req = 1'b0; a1.if_addr = '0; a1.d_req = 1'b0; a1.d_we = 1'b0;
    a1.d_addr = '0;   a1.d_wdata = '0;
    a3.if_req = 1'b0; a3.if_addr = '0; a3.d_req = 1'b0; a3.d_we = 1'b0;
    a3.d_addr = '0;   a3.d_wdata = '0;
    preload(32'h204, 32'hCAFE_F00D);
    preload(32'h400, 32'h1234_5678);
    preload(32'h300, 32'h0BAD_F00D);
    test_reset;
    test_fetch_l1;
    test_store_load;
    test_both;
    test_starve;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
